// File: rtl/text_cursor_ctrl.sv
// Cursor and terminal controller: turns ASCII/scancode strobes into character-cell
// writes and a cursor position, with a hardware clear-screen sweep.
module text_cursor_ctrl #(
  parameter int unsigned COLS      = 16,
  parameter int unsigned ROWS      = 2,
  parameter int unsigned COL_W     = $clog2(COLS),
  parameter int unsigned ROW_W     = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int unsigned WRAP_MODE = 1,
  parameter int unsigned TAB_STOP  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ascii_vld,
  input  logic [7:0]       ascii,
  input  logic             scancode_vld,
  input  logic [7:0]       scancode,
  input  logic             clear_req,
  output logic             wr_en,
  output logic [COL_W-1:0] wr_col,
  output logic [ROW_W-1:0] wr_row,
  output logic [7:0]       wr_symbol,
  output logic [COL_W-1:0] cursor_col,
  output logic [ROW_W-1:0] cursor_row,
  output logic             busy
);

  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_MAX  = ROW_W'(ROWS - 1);
  localparam logic [COL_W:0]   TAB_MASK = ~((COL_W+1)'(TAB_STOP - 1));
  localparam logic [COL_W:0]   TAB_LIM  = (COL_W+1)'(COLS);
  localparam logic [7:0]       SPACE    = 8'h20;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [COL_W-1:0] sw_col;
  logic [ROW_W-1:0] sw_row;
  logic             sw_done;

  logic [COL_W-1:0] nxt_col;
  logic [ROW_W-1:0] nxt_row;
  logic             do_wr;
  logic [COL_W-1:0] wr_col_n;
  logic [ROW_W-1:0] wr_row_n;
  logic [7:0]       wr_sym_n;
  logic [COL_W:0]   tab_col;
  logic [ROW_W-1:0] enter_row;
  logic             wrap;

  // Next cursor position and optional cell write for an ASCII or scancode strobe.
  always_comb begin
    wrap      = (WRAP_MODE != 0);
    nxt_col   = cursor_col;
    nxt_row   = cursor_row;
    do_wr     = 1'b0;
    wr_col_n  = cursor_col;
    wr_row_n  = cursor_row;
    wr_sym_n  = ascii;
    tab_col   = ({1'b0, cursor_col} & TAB_MASK) + (COL_W+1)'(TAB_STOP);
    enter_row = (cursor_row != ROW_MAX) ? cursor_row + ROW_W'(1)
              : (wrap ? '0 : ROW_MAX);
    if (ascii_vld) begin
      if (ascii >= 8'h20 && ascii <= 8'h7E) begin
        do_wr = 1'b1;
        if (cursor_col != COL_MAX) begin
          nxt_col = cursor_col + COL_W'(1);
        end else if (cursor_row != ROW_MAX) begin
          nxt_col = '0;
          nxt_row = cursor_row + ROW_W'(1);
        end else if (wrap) begin
          nxt_col = '0;
          nxt_row = '0;
        end
      end else if (ascii == 8'h08) begin
        if (cursor_col != '0) begin
          nxt_col  = cursor_col - COL_W'(1);
          do_wr    = 1'b1;
          wr_col_n = cursor_col - COL_W'(1);
          wr_sym_n = SPACE;
        end else if (cursor_row != '0) begin
          nxt_col  = COL_MAX;
          nxt_row  = cursor_row - ROW_W'(1);
          do_wr    = 1'b1;
          wr_col_n = COL_MAX;
          wr_row_n = cursor_row - ROW_W'(1);
          wr_sym_n = SPACE;
        end
      end else if (ascii == 8'h0D || ascii == 8'h0A) begin
        nxt_col = '0;
        nxt_row = enter_row;
      end else if (ascii == 8'h09) begin
        if (tab_col >= TAB_LIM) begin
          nxt_col = '0;
          nxt_row = enter_row;
        end else begin
          nxt_col = COL_W'(tab_col);
        end
      end
    end else if (scancode_vld) begin
      case (scancode)
        8'h6B: nxt_col = (cursor_col != '0) ? cursor_col - COL_W'(1)
                       : (wrap ? COL_MAX : cursor_col);
        8'h74: nxt_col = (cursor_col != COL_MAX) ? cursor_col + COL_W'(1)
                       : (wrap ? '0 : cursor_col);
        8'h75: nxt_row = (cursor_row != '0) ? cursor_row - ROW_W'(1)
                       : (wrap ? ROW_MAX : cursor_row);
        8'h72: nxt_row = (cursor_row != ROW_MAX) ? cursor_row + ROW_W'(1)
                       : (wrap ? '0 : cursor_row);
        default: ;
      endcase
    end
  end

  // Control FSM; the sweep issues cell (0,0) on the accepting edge so busy spans the writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cursor_col <= '0;
      cursor_row <= '0;
      wr_en      <= 1'b0;
      wr_col     <= '0;
      wr_row     <= '0;
      wr_symbol  <= SPACE;
      busy       <= 1'b0;
      sw_col     <= '0;
      sw_row     <= '0;
      sw_done    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE: begin
          if (clear_req) begin
            state     <= CLEAR;
            busy      <= 1'b1;
            wr_en     <= 1'b1;
            wr_col    <= '0;
            wr_row    <= '0;
            wr_symbol <= SPACE;
            sw_col    <= COL_W'(1);
            sw_row    <= '0;
            sw_done   <= 1'b0;
          end else begin
            cursor_col <= nxt_col;
            cursor_row <= nxt_row;
            if (do_wr) begin
              wr_en     <= 1'b1;
              wr_col    <= wr_col_n;
              wr_row    <= wr_row_n;
              wr_symbol <= wr_sym_n;
            end
          end
        end
        CLEAR: begin
          if (sw_done) begin
            state      <= IDLE;
            busy       <= 1'b0;
            cursor_col <= '0;
            cursor_row <= '0;
          end else begin
            wr_en     <= 1'b1;
            wr_col    <= sw_col;
            wr_row    <= sw_row;
            wr_symbol <= SPACE;
            if (sw_col == COL_MAX && sw_row == ROW_MAX) begin
              sw_done <= 1'b1;
            end else if (sw_col == COL_MAX) begin
              sw_col <= '0;
              sw_row <= sw_row + ROW_W'(1);
            end else begin
              sw_col <= sw_col + COL_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_ctrl.sv
// Bench for text_cursor_ctrl: wrap 16x2, clamp 16x2 and wrap 10x3/tab 2 instances,
// checked against a linear-index reference model plus directed vectors.
module tb_text_cursor_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ascii_vld = 1'b0;
  logic [7:0] ascii = 8'h00;
  logic       scancode_vld = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       clear_req = 1'b0;

  always #5 clk = ~clk;

  logic       we0, we1, we2, bz0, bz1, bz2;
  logic [3:0] wc0, wc1, wc2, cc0, cc1, cc2;
  logic [0:0] wr0, wr1, cr0, cr1;
  logic [1:0] wr2, cr2;
  logic [7:0] ws0, ws1, ws2;

  text_cursor_ctrl #(.COLS(16), .ROWS(2), .WRAP_MODE(1), .TAB_STOP(4)) u_w (
    .clk(clk), .rst_n(rst_n), .ascii_vld(ascii_vld), .ascii(ascii),
    .scancode_vld(scancode_vld), .scancode(scancode), .clear_req(clear_req),
    .wr_en(we0), .wr_col(wc0), .wr_row(wr0), .wr_symbol(ws0),
    .cursor_col(cc0), .cursor_row(cr0), .busy(bz0));

  text_cursor_ctrl #(.COLS(16), .ROWS(2), .WRAP_MODE(0), .TAB_STOP(4)) u_c (
    .clk(clk), .rst_n(rst_n), .ascii_vld(ascii_vld), .ascii(ascii),
    .scancode_vld(scancode_vld), .scancode(scancode), .clear_req(clear_req),
    .wr_en(we1), .wr_col(wc1), .wr_row(wr1), .wr_symbol(ws1),
    .cursor_col(cc1), .cursor_row(cr1), .busy(bz1));

  text_cursor_ctrl #(.COLS(10), .ROWS(3), .WRAP_MODE(1), .TAB_STOP(2)) u_t (
    .clk(clk), .rst_n(rst_n), .ascii_vld(ascii_vld), .ascii(ascii),
    .scancode_vld(scancode_vld), .scancode(scancode), .clear_req(clear_req),
    .wr_en(we2), .wr_col(wc2), .wr_row(wr2), .wr_symbol(ws2),
    .cursor_col(cc2), .cursor_row(cr2), .busy(bz2));

  int o_we[3], o_wc[3], o_wr[3], o_ws[3], o_cc[3], o_cr[3], o_bz[3];
  assign o_we[0] = int'(we0); assign o_we[1] = int'(we1); assign o_we[2] = int'(we2);
  assign o_wc[0] = int'(wc0); assign o_wc[1] = int'(wc1); assign o_wc[2] = int'(wc2);
  assign o_wr[0] = int'(wr0); assign o_wr[1] = int'(wr1); assign o_wr[2] = int'(wr2);
  assign o_ws[0] = int'(ws0); assign o_ws[1] = int'(ws1); assign o_ws[2] = int'(ws2);
  assign o_cc[0] = int'(cc0); assign o_cc[1] = int'(cc1); assign o_cc[2] = int'(cc2);
  assign o_cr[0] = int'(cr0); assign o_cr[1] = int'(cr1); assign o_cr[2] = int'(cr2);
  assign o_bz[0] = int'(bz0); assign o_bz[1] = int'(bz1); assign o_bz[2] = int'(bz2);

  int p_cols[3] = '{16, 16, 10};
  int p_rows[3] = '{2, 2, 3};
  int p_wrap[3] = '{1, 0, 1};
  int p_tab[3]  = '{4, 4, 2};

  int m_col[3], m_row[3], m_we[3], m_wc[3], m_wr[3], m_ws[3], m_bz[3], m_clr[3], m_sidx[3];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_col[i] = 0; m_row[i] = 0; m_we[i] = 0; m_wc[i] = 0; m_wr[i] = 0;
      m_ws[i] = 32'h20; m_bz[i] = 0; m_clr[i] = 0; m_sidx[i] = 0;
    end
  endtask

  task automatic mwrite(input int i, input int c, input int r, input int s);
    m_we[i] = 1; m_wc[i] = c; m_wr[i] = r; m_ws[i] = s;
  endtask

  task automatic menter(input int i);
    m_col[i] = 0;
    if (m_row[i] < p_rows[i] - 1) m_row[i]++;
    else if (p_wrap[i] != 0) m_row[i] = 0;
  endtask

  // Reference behaviour over a linear cell index; one call per clock edge.
  task automatic model_step(input int i);
    int n, idx, a, t;
    n = p_cols[i] * p_rows[i];
    idx = m_row[i] * p_cols[i] + m_col[i];
    a = int'(ascii);
    m_we[i] = 0;
    if (m_clr[i] != 0) begin
      if (m_sidx[i] < n) begin
        mwrite(i, m_sidx[i] % p_cols[i], m_sidx[i] / p_cols[i], 32'h20);
        m_sidx[i]++;
      end else begin
        m_clr[i] = 0; m_bz[i] = 0; m_col[i] = 0; m_row[i] = 0;
      end
    end else if (clear_req) begin
      m_clr[i] = 1; m_bz[i] = 1; m_sidx[i] = 1;
      mwrite(i, 0, 0, 32'h20);
    end else if (ascii_vld) begin
      if (a >= 32'h20 && a <= 32'h7E) begin
        mwrite(i, m_col[i], m_row[i], a);
        if (idx == n - 1) idx = (p_wrap[i] != 0) ? 0 : idx;
        else idx++;
        m_col[i] = idx % p_cols[i]; m_row[i] = idx / p_cols[i];
      end else if (a == 32'h08) begin
        if (idx > 0) begin
          idx--;
          m_col[i] = idx % p_cols[i]; m_row[i] = idx / p_cols[i];
          mwrite(i, m_col[i], m_row[i], 32'h20);
        end
      end else if (a == 32'h0D || a == 32'h0A) begin
        menter(i);
      end else if (a == 32'h09) begin
        t = (m_col[i] / p_tab[i] + 1) * p_tab[i];
        if (t >= p_cols[i]) menter(i);
        else m_col[i] = t;
      end
    end else if (scancode_vld) begin
      case (scancode)
        8'h6B: if (m_col[i] > 0) m_col[i]--; else if (p_wrap[i] != 0) m_col[i] = p_cols[i] - 1;
        8'h74: if (m_col[i] < p_cols[i] - 1) m_col[i]++; else if (p_wrap[i] != 0) m_col[i] = 0;
        8'h75: if (m_row[i] > 0) m_row[i]--; else if (p_wrap[i] != 0) m_row[i] = p_rows[i] - 1;
        8'h72: if (m_row[i] < p_rows[i] - 1) m_row[i]++; else if (p_wrap[i] != 0) m_row[i] = 0;
        default: ;
      endcase
    end
  endtask

  task automatic cmp_model();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("i%0d_wr_en", i), o_we[i], m_we[i]);
      chk($sformatf("i%0d_wr_col", i), o_wc[i], m_wc[i]);
      chk($sformatf("i%0d_wr_row", i), o_wr[i], m_wr[i]);
      chk($sformatf("i%0d_wr_symbol", i), o_ws[i], m_ws[i]);
      chk($sformatf("i%0d_cursor_col", i), o_cc[i], m_col[i]);
      chk($sformatf("i%0d_cursor_row", i), o_cr[i], m_row[i]);
      chk($sformatf("i%0d_busy", i), o_bz[i], m_bz[i]);
    end
  endtask

  // One clock: inputs already driven, step model on the edge, compare, drop strobes.
  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) model_step(i);
    cmp_model();
    ascii_vld = 1'b0; scancode_vld = 1'b0; clear_req = 1'b0;
  endtask

  task automatic drive(input bit av, input bit [7:0] a, input bit sv, input bit [7:0] s, input bit cr);
    ascii_vld = av; ascii = a; scancode_vld = sv; scancode = s; clear_req = cr;
  endtask

  typedef struct {
    bit av; bit [7:0] a; bit sv; bit [7:0] s;
    int w_we, w_wc, w_wr, w_ws, w_cc, w_cr;
    int c_we, c_cc, c_cr;
  } vec_t;

  vec_t vec[22];

  initial begin
    int we_cnt, bz_cnt, guard, r;

    vec[0]  = '{0, 8'h00, 1, 8'h72, 0, 0, 0, 32'h20, 0, 1, 0, 0, 1};
    vec[1]  = '{0, 8'h00, 1, 8'h6B, 0, 0, 0, 32'h20, 15, 1, 0, 0, 1};
    vec[2]  = '{1, 8'h41, 0, 8'h00, 1, 15, 1, 32'h41, 0, 0, 1, 1, 1};
    vec[3]  = '{1, 8'h78, 1, 8'h74, 1, 0, 0, 32'h78, 1, 0, 1, 2, 1};
    vec[4]  = '{1, 8'h08, 0, 8'h00, 1, 0, 0, 32'h20, 0, 0, 1, 1, 1};
    vec[5]  = '{1, 8'h08, 0, 8'h00, 0, 0, 0, 32'h20, 0, 0, 1, 0, 1};
    vec[6]  = '{1, 8'h08, 0, 8'h00, 0, 0, 0, 32'h20, 0, 0, 1, 15, 0};
    vec[7]  = '{0, 8'h00, 1, 8'h75, 0, 0, 0, 32'h20, 0, 1, 0, 15, 0};
    vec[8]  = '{1, 8'h0D, 0, 8'h00, 0, 0, 0, 32'h20, 0, 0, 0, 0, 1};
    vec[9]  = '{1, 8'h09, 0, 8'h00, 0, 0, 0, 32'h20, 4, 0, 0, 4, 1};
    vec[10] = '{0, 8'h00, 1, 8'h74, 0, 0, 0, 32'h20, 5, 0, 0, 5, 1};
    vec[11] = '{1, 8'h09, 0, 8'h00, 0, 0, 0, 32'h20, 8, 0, 0, 8, 1};
    vec[12] = '{1, 8'h09, 0, 8'h00, 0, 0, 0, 32'h20, 12, 0, 0, 12, 1};
    vec[13] = '{0, 8'h00, 1, 8'h74, 0, 0, 0, 32'h20, 13, 0, 0, 13, 1};
    vec[14] = '{1, 8'h09, 0, 8'h00, 0, 0, 0, 32'h20, 0, 1, 0, 0, 1};
    vec[15] = '{1, 8'h0A, 0, 8'h00, 0, 0, 0, 32'h20, 0, 0, 0, 0, 1};
    vec[16] = '{1, 8'h07, 0, 8'h00, 0, 0, 0, 32'h20, 0, 0, 0, 0, 1};
    vec[17] = '{0, 8'h00, 1, 8'h6B, 0, 0, 0, 32'h20, 15, 0, 0, 0, 1};
    vec[18] = '{0, 8'h00, 1, 8'h74, 0, 0, 0, 32'h20, 0, 0, 0, 1, 1};
    vec[19] = '{0, 8'h00, 1, 8'h72, 0, 0, 0, 32'h20, 0, 1, 0, 1, 1};
    vec[20] = '{0, 8'h00, 1, 8'h72, 0, 0, 0, 32'h20, 0, 0, 0, 1, 1};
    vec[21] = '{0, 8'h00, 1, 8'h12, 0, 0, 0, 32'h20, 0, 0, 0, 1, 1};

    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wr_en", o_we[0], 0);
    chk("rst_wr_col", o_wc[0], 0);
    chk("rst_wr_row", o_wr[0], 0);
    chk("rst_wr_symbol", o_ws[0], 32'h20);
    chk("rst_cursor_col", o_cc[0], 0);
    chk("rst_cursor_row", o_cr[0], 0);
    chk("rst_busy", o_bz[0], 0);

    for (int k = 0; k < 22; k++) begin
      drive(vec[k].av, vec[k].a, vec[k].sv, vec[k].s, 1'b0);
      cycle();
      chk($sformatf("v%0d_w_wr_en", k), o_we[0], vec[k].w_we);
      chk($sformatf("v%0d_w_wr_col", k), o_wc[0], vec[k].w_wc);
      chk($sformatf("v%0d_w_wr_row", k), o_wr[0], vec[k].w_wr);
      chk($sformatf("v%0d_w_wr_symbol", k), o_ws[0], vec[k].w_ws);
      chk($sformatf("v%0d_w_cursor_col", k), o_cc[0], vec[k].w_cc);
      chk($sformatf("v%0d_w_cursor_row", k), o_cr[0], vec[k].w_cr);
      chk($sformatf("v%0d_c_wr_en", k), o_we[1], vec[k].c_we);
      chk($sformatf("v%0d_c_cursor_col", k), o_cc[1], vec[k].c_cc);
      chk($sformatf("v%0d_c_cursor_row", k), o_cr[1], vec[k].c_cr);
    end

    // Clamp instance to the last cell, then print there.
    repeat (14) begin drive(0, 8'h00, 1, 8'h74, 0); cycle(); end
    drive(1, 8'h41, 0, 8'h00, 0); cycle();
    chk("clamp_last_wr_en", o_we[1], 1);
    chk("clamp_last_wr_col", o_wc[1], 15);
    chk("clamp_last_wr_row", o_wr[1], 1);
    chk("clamp_last_wr_symbol", o_ws[1], 32'h41);
    chk("clamp_last_cursor_col", o_cc[1], 15);
    chk("clamp_last_cursor_row", o_cr[1], 1);
    chk("wrap_cursor_col_15", o_cc[0], 15);

    // Move wrap instance to (7,1), then clear with a simultaneous ascii strobe.
    drive(0, 8'h00, 1, 8'h72, 0); cycle();
    repeat (8) begin drive(0, 8'h00, 1, 8'h6B, 0); cycle(); end
    chk("pre_clear_col", o_cc[0], 7);
    chk("pre_clear_row", o_cr[0], 1);
    drive(1, 8'h51, 0, 8'h00, 1); cycle();
    chk("clear_first_col", o_wc[0], 0);
    chk("clear_first_row", o_wr[0], 0);
    we_cnt = o_we[0]; bz_cnt = o_bz[0]; guard = 0;
    while (o_bz[0] != 0 && guard < 100) begin
      drive(guard[0], 8'h5A, 1'b0, 8'h00, guard[2]);
      cycle();
      we_cnt += o_we[0]; bz_cnt += o_bz[0]; guard++;
    end
    chk("clear_guard", int'(guard < 100), 1);
    chk("clear_writes", we_cnt, 32);
    chk("clear_busy_cycles", bz_cnt, 32);
    chk("clear_end_col", o_cc[0], 0);
    chk("clear_end_row", o_cr[0], 0);
    repeat (5) cycle();

    // Reset in the middle of a sweep, at the tenth write.
    drive(0, 8'h00, 0, 8'h00, 1); cycle();
    repeat (9) cycle();
    chk("mid_sweep_wr_col", o_wc[0], 9);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", o_bz[0], 0);
    chk("abort_wr_en", o_we[0], 0);
    chk("abort_cursor_col", o_cc[0], 0);
    chk("abort_cursor_row", o_cr[0], 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomised traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4: ascii = 8'($urandom_range(32, 126));
        5: ascii = 8'h08;
        6: ascii = 8'h09;
        7: ascii = 8'h0D;
        8: ascii = 8'h0A;
        default: ascii = 8'($urandom_range(0, 255));
      endcase
      ascii_vld = ($urandom_range(0, 1) == 1);
      scancode_vld = ($urandom_range(0, 9) < 4);
      case ($urandom_range(0, 4))
        0: scancode = 8'h6B;
        1: scancode = 8'h74;
        2: scancode = 8'h75;
        3: scancode = 8'h72;
        default: scancode = 8'($urandom_range(0, 255));
      endcase
      clear_req = ($urandom_range(0, 149) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
